// File: rtl/complement_serial_unit.sv
// rtl/complement_serial_unit.sv - digit-serial pass/ones/twos/abs complement engine
//
// Operand is accepted in IDLE, walked LSB digit first through a registered
// carry during BUSY (WIDTH/DIGIT cycles), and presented in DONE until the
// consumer takes it. All outputs come straight from registers.

module complement_serial_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CW-1:0]    LAST_DIGIT = CW'(NDIG - 1);
  localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_ONES = 2'b01;
  localparam logic [1:0] MODE_TWOS = 2'b10;

  // Reject parameter sets that cannot be split into whole digits.
  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("complement_serial_unit: need WIDTH >= 2, 1 <= DIGIT <= WIDTH, WIDTH %% DIGIT == 0");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opnd;     // operand, consumed from the bottom
  logic [WIDTH-1:0] res;      // result, filled from the top
  logic             invert;
  logic             carry;
  logic             ovf;
  logic [CW-1:0]    cnt;

  logic                   acc_invert;
  logic                   acc_carry;
  logic                   acc_ovf;
  logic [DIGIT-1:0]       dig;
  logic [DIGIT:0]         sum;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;

  // Decode the mode of the word being offered into invert flag and initial carry.
  always_comb begin
    acc_invert = 1'b0;
    acc_carry  = 1'b0;
    case (in_mode)
      MODE_PASS: begin
        acc_invert = 1'b0;
        acc_carry  = 1'b0;
      end
      MODE_ONES: begin
        acc_invert = 1'b1;
        acc_carry  = 1'b0;
      end
      MODE_TWOS: begin
        acc_invert = 1'b1;
        acc_carry  = 1'b1;
      end
      default: begin
        // abs: negate only negative operands
        acc_invert = in_data[WIDTH-1];
        acc_carry  = in_data[WIDTH-1];
      end
    endcase
    // Negating the most-negative value has no representable result.
    acc_ovf = acc_invert & acc_carry & (in_data == MOST_NEG);
  end

  // One digit of (optionally inverted) operand plus the running carry.
  always_comb begin
    dig      = opnd[DIGIT-1:0];
    sum      = {1'b0, dig ^ {DIGIT{invert}}} + {{DIGIT{1'b0}}, carry};
    res_cat  = {sum[DIGIT-1:0], res};
    res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
  end

  // Control FSM and datapath registers; outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      opnd         <= '0;
      res          <= '0;
      invert       <= 1'b0;
      carry        <= 1'b0;
      ovf          <= 1'b0;
      cnt          <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            opnd     <= in_data;
            res      <= '0;
            invert   <= acc_invert;
            carry    <= acc_carry;
            ovf      <= acc_ovf;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          opnd  <= opnd >> DIGIT;
          res   <= res_next;
          carry <= sum[DIGIT];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_DIGIT) begin
            // Final carry is dropped: result is modulo 2^WIDTH.
            out_data     <= res_next;
            out_overflow <= ovf;
            out_valid    <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_complement_serial_unit.sv
// tb/tb_complement_serial_unit.sv - randomized self-checking bench for complement_serial_unit

module tb_complement_serial_unit;

  localparam logic [1:0] M_PASS = 2'b00;
  localparam logic [1:0] M_ONES = 2'b01;
  localparam logic [1:0] M_TWOS = 2'b10;
  localparam logic [1:0] M_ABS  = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        iv8, ir8, ov8, or8, of8;
  logic [7:0]  d8, q8;
  logic [1:0]  m8;

  logic        iv16, ir16, ov16, or16, of16;
  logic [15:0] d16, q16;
  logic [1:0]  m16;

  complement_serial_unit #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .in_data(d8), .in_mode(m8),
    .out_valid(ov8), .out_ready(or8), .out_data(q8), .out_overflow(of8)
  );

  complement_serial_unit #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16), .in_data(d16), .in_mode(m16),
    .out_valid(ov16), .out_ready(or16), .out_data(q16), .out_overflow(of16)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: signed arithmetic on integers, result taken modulo 2^w.
  // Returns {overflow, result}.
  function automatic logic [16:0] model(input int w, input logic [15:0] x, input logic [1:0] m);
    longint modulus, u, s, truev, r;
    logic   ovf;
    logic [16:0] out;
    modulus = longint'(1) << w;
    u = longint'(x) & (modulus - 1);
    s = (u >= modulus / 2) ? u - modulus : u;
    case (m)
      M_PASS:  truev = u;
      M_ONES:  truev = modulus - 1 - u;
      M_TWOS:  truev = -s;
      default: truev = (s < 0) ? -s : s;
    endcase
    ovf = (m == M_TWOS || m == M_ABS) && (truev > modulus / 2 - 1);
    r = ((truev % modulus) + modulus) % modulus;
    out = '0;
    out[15:0] = r[15:0];
    out[16] = ovf;
    return out;
  endfunction

  // ---------------- 8-bit / 1-bit-digit instance ----------------
  task automatic send8(input logic [7:0] x, input logic [1:0] m);
    int k = 0;
    while (!ir8 && k < 50) begin @(posedge clk); #1; k++; end
    check("in_ready8_wait", 32'(k < 50), 32'd1);
    iv8 = 1'b1; d8 = x; m8 = m;
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic wait_valid8(output int n);
    n = 0;
    while (!ov8 && n < 64) begin @(posedge clk); #1; n++; end
  endtask

  task automatic op8(input logic [7:0] x, input logic [1:0] m,
                     input logic [7:0] exp_q, input logic exp_f, input string tag);
    int n;
    or8 = 1'b1;
    send8(x, m);
    wait_valid8(n);
    check({tag, "_lat"}, 32'(n), 32'd8);
    check({tag, "_data"}, 32'(q8), 32'(exp_q));
    check({tag, "_ovf"}, 32'(of8), 32'(exp_f));
    @(posedge clk); #1;
    check({tag, "_vdrop"}, 32'(ov8), 32'd0);
    check({tag, "_rdy"}, 32'(ir8), 32'd1);
  endtask

  // ---------------- 16-bit / 4-bit-digit instance ----------------
  task automatic op16(input logic [15:0] x, input logic [1:0] m,
                      input logic [15:0] exp_q, input logic exp_f, input string tag);
    int k = 0;
    int n = 0;
    or16 = 1'b1;
    while (!ir16 && k < 50) begin @(posedge clk); #1; k++; end
    check({tag, "_rdywait"}, 32'(k < 50), 32'd1);
    iv16 = 1'b1; d16 = x; m16 = m;
    @(posedge clk); #1;
    iv16 = 1'b0;
    while (!ov16 && n < 64) begin @(posedge clk); #1; n++; end
    check({tag, "_lat"}, 32'(n), 32'd4);
    check({tag, "_data"}, 32'(q16), 32'(exp_q));
    check({tag, "_ovf"}, 32'(of16), 32'(exp_f));
    @(posedge clk); #1;
    check({tag, "_vdrop"}, 32'(ov16), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] e;
    logic [7:0]  x8;
    logic [15:0] x16;
    logic [1:0]  mm;
    int n;

    rst_n = 1'b0;
    iv8 = 1'b0; d8 = '0; m8 = '0; or8 = 1'b1;
    iv16 = 1'b0; d16 = '0; m16 = '0; or16 = 1'b1;
    #23;
    check("rst_ov8", 32'(ov8), 32'd0);
    check("rst_q8", 32'(q8), 32'd0);
    check("rst_of8", 32'(of8), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_ir8", 32'(ir8), 32'd1);
    check("rst_ir16", 32'(ir16), 32'd1);
    check("rst_ov16", 32'(ov16), 32'd0);

    // Directed cases from the 8-bit plan
    op8(8'hAA, M_TWOS, 8'h56, 1'b0, "aa_twos");
    op8(8'hAA, M_ONES, 8'h55, 1'b0, "aa_ones");
    op8(8'hAA, M_PASS, 8'hAA, 1'b0, "aa_pass");
    op8(8'h80, M_TWOS, 8'h80, 1'b1, "80_twos");
    op8(8'h80, M_ABS,  8'h80, 1'b1, "80_abs");
    op8(8'h80, M_ONES, 8'h7F, 1'b0, "80_ones");
    op8(8'h00, M_TWOS, 8'h00, 1'b0, "00_twos");
    op8(8'hF6, M_ABS,  8'h0A, 1'b0, "f6_abs");
    op8(8'h05, M_ABS,  8'h05, 1'b0, "05_abs");

    // Backpressure: result held, input side closed, stray in_valid ignored
    or8 = 1'b0;
    send8(8'h3C, M_TWOS);
    wait_valid8(n);
    check("bp_lat", 32'(n), 32'd8);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin iv8 = 1'b1; d8 = 8'h11; m8 = M_PASS; end
      @(posedge clk); #1;
      iv8 = 1'b0;
      check("bp_valid", 32'(ov8), 32'd1);
      check("bp_data", 32'(q8), 32'h00C4);
      check("bp_ovf", 32'(of8), 32'd0);
      check("bp_inrdy", 32'(ir8), 32'd0);
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    check("bp_vdrop", 32'(ov8), 32'd0);
    check("bp_idle", 32'(ir8), 32'd1);
    check("bp_hold", 32'(q8), 32'h00C4);
    repeat (10) @(posedge clk);
    #1;
    check("bp_nostray", 32'(ov8), 32'd0);

    // Asynchronous reset three cycles into BUSY
    send8(8'h5A, M_PASS);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("amid_ov", 32'(ov8), 32'd0);
    check("amid_q", 32'(q8), 32'd0);
    check("amid_of", 32'(of8), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("amid_ir", 32'(ir8), 32'd1);
    op8(8'h01, M_TWOS, 8'hFF, 1'b0, "post_rst");

    // Randomised 8-bit runs against the model
    for (int i = 0; i < 40; i++) begin
      x8 = 8'($urandom);
      if (i % 10 == 0) x8 = 8'h80;
      mm = 2'($urandom_range(0, 3));
      e = model(8, {8'h00, x8}, mm);
      op8(x8, mm, e[7:0], e[16], "rnd8");
    end

    // 16-bit, 4-bit digits
    op16(16'h0001, M_TWOS, 16'hFFFF, 1'b0, "w16_1_twos");
    op16(16'h8000, M_TWOS, 16'h8000, 1'b1, "w16_min_twos");
    op16(16'h0000, M_TWOS, 16'h0000, 1'b0, "w16_0_twos");
    for (int i = 0; i < 40; i++) begin
      x16 = 16'($urandom);
      if (i % 10 == 3) x16 = 16'h8000;
      mm = 2'(i % 4);
      e = model(16, x16, mm);
      op16(x16, mm, e[15:0], e[16], "rnd16");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
